// File: rtl/dm_lsu_mem_if.sv
// rtl/dm_lsu_mem_if.sv - MEM-stage load/store request and response bundle
interface dm_lsu_mem_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
);
    logic                  MemRead;
    logic                  MemWrite;
    logic [DM_ADDRESS-1:0] a;
    logic [DATA_W-1:0]     wd;
    logic [2:0]            Funct3;
    logic [DATA_W-1:0]     rd;
    logic                  rd_valid;
    logic                  busy;
    logic                  misalign_err;

    modport master (
        output MemRead, MemWrite, a, wd, Funct3,
        input  rd, rd_valid, busy, misalign_err
    );

    modport slave (
        input  MemRead, MemWrite, a, wd, Funct3,
        output rd, rd_valid, busy, misalign_err
    );
endinterface

// File: rtl/dm_lsu_mem.sv
// rtl/dm_lsu_mem.sv - data memory with RISC-V load/store aligner; DM_MISALIGN_EN enables split word-crossing accesses
module dm_lsu_mem #(
    parameter int    DM_ADDRESS = 9,
    parameter int    DATA_W     = 32,
    parameter string INIT_FILE  = ""
) (
    input  logic        clk,
    input  logic        rst_n,
    dm_lsu_mem_if.slave bus
);
    localparam int WI    = DM_ADDRESS - 2;
    localparam int DEPTH = 1 << WI;

    if (DATA_W != 32) begin : g_bad_width
        $error("dm_lsu_mem: DATA_W must be 32");
    end

    logic [31:0] mem [DEPTH];

`ifdef DM_MISALIGN_EN
    typedef enum logic {IDLE, SPLIT} state_t;
    state_t                state;
    logic [DM_ADDRESS-1:0] l_a;
    logic [31:0]           l_wd;
    logic [2:0]            l_f3;
    logic                  l_write;
    logic [31:0]           l_lo;
`endif

    logic                  in_split;
    logic                  accept;
    logic [DM_ADDRESS-1:0] cur_a;
    logic [31:0]           cur_wd;
    logic [2:0]            cur_f3;
    logic                  cur_write;
    logic                  cur_read;
    logic [3:0]            size_mask;
    logic [7:0]            mask8;
    logic [63:0]           data64;
    logic                  crossing;
    logic [WI-1:0]         word_idx;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic                  wr_en;
    logic [31:0]           rdata;
    logic [31:0]           lo_word;
    logic [31:0]           hi_word;
    logic [31:0]           ld_raw;
    logic [31:0]           ld_ext;

    always_comb begin
        cur_a     = bus.a;
        cur_wd    = bus.wd;
        cur_f3    = bus.Funct3;
        cur_write = bus.MemWrite;
        cur_read  = bus.MemRead & ~bus.MemWrite;
        in_split  = 1'b0;
`ifdef DM_MISALIGN_EN
        if (state == SPLIT) begin
            in_split  = 1'b1;
            cur_a     = l_a;
            cur_wd    = l_wd;
            cur_f3    = l_f3;
            cur_write = l_write;
            cur_read  = ~l_write;
        end
`endif
        accept = ~in_split & (bus.MemRead | bus.MemWrite);

        case (cur_f3)
            3'b000, 3'b100: size_mask = 4'b0001;
            3'b001, 3'b101: size_mask = 4'b0011;
            default:        size_mask = 4'b1111;
        endcase

        // Lanes/bytes spread across an 8-byte window: low half is word w, high half is word w+1
        mask8    = {4'b0000, size_mask} << cur_a[1:0];
        data64   = {32'h0, cur_wd} << {cur_a[1:0], 3'b000};
        crossing = |mask8[7:4];

        word_idx = cur_a[DM_ADDRESS-1:2] + {{(WI-1){1'b0}}, in_split};
        wr_be    = in_split ? mask8[7:4]   : mask8[3:0];
        wr_data  = in_split ? data64[63:32] : data64[31:0];
`ifdef DM_MISALIGN_EN
        wr_en    = in_split ? l_write : (accept & cur_write);
        lo_word  = in_split ? l_lo : mem[word_idx];
`else
        wr_en    = accept & cur_write & ~crossing;
        lo_word  = mem[word_idx];
`endif
        rdata    = mem[word_idx];
        hi_word  = in_split ? rdata : 32'h0;

        case (cur_a[1:0])
            2'd0:    ld_raw = lo_word;
            2'd1:    ld_raw = {hi_word[7:0],  lo_word[31:8]};
            2'd2:    ld_raw = {hi_word[15:0], lo_word[31:16]};
            default: ld_raw = {hi_word[23:0], lo_word[31:24]};
        endcase

        case (cur_f3)
            3'b000:  ld_ext = {{24{ld_raw[7]}},  ld_raw[7:0]};
            3'b001:  ld_ext = {{16{ld_raw[15]}}, ld_raw[15:0]};
            3'b100:  ld_ext = {24'h0, ld_raw[7:0]};
            3'b101:  ld_ext = {16'h0, ld_raw[15:0]};
            default: ld_ext = ld_raw;
        endcase
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (wr_en && wr_be[i]) mem[word_idx][8*i +: 8] <= wr_data[8*i +: 8];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rd           <= '0;
            bus.rd_valid     <= 1'b0;
            bus.busy         <= 1'b0;
            bus.misalign_err <= 1'b0;
`ifdef DM_MISALIGN_EN
            state            <= IDLE;
            l_a              <= '0;
            l_wd             <= '0;
            l_f3             <= '0;
            l_write          <= 1'b0;
            l_lo             <= '0;
`endif
        end else begin
            bus.rd_valid     <= 1'b0;
            bus.misalign_err <= 1'b0;
`ifdef DM_MISALIGN_EN
            case (state)
                IDLE: begin
                    if (accept) begin
                        bus.misalign_err <= crossing;
                        if (crossing) begin
                            state    <= SPLIT;
                            bus.busy <= 1'b1;
                            l_a      <= bus.a;
                            l_wd     <= bus.wd;
                            l_f3     <= bus.Funct3;
                            l_write  <= bus.MemWrite;
                            l_lo     <= rdata;
                        end else if (cur_read) begin
                            bus.rd       <= ld_ext;
                            bus.rd_valid <= 1'b1;
                        end
                    end
                end
                default: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                    if (cur_read) begin
                        bus.rd       <= ld_ext;
                        bus.rd_valid <= 1'b1;
                    end
                end
            endcase
`else
            bus.busy <= 1'b0;
            if (accept) begin
                bus.misalign_err <= crossing;
                if (cur_read) begin
                    bus.rd       <= crossing ? 32'h0 : ld_ext;
                    bus.rd_valid <= 1'b1;
                end
            end
`endif
        end
    end
endmodule
